// File: rtl/nav_sequencer.sv
// rtl/nav_sequencer.sv - line-following car motion sequencer with route command FIFO
//
// Optional feature macro: NAV_LOST_RECOVER_EN
//   undefined : a lost line (s == 000 for LOST_MAX cycles) goes straight to ERROR
//   defined   : a lost line first steers LITTLE_LEFT/LITTLE_RIGHT for up to
//               LOST_MAX further cycles, then ERROR if the line is still absent
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         single-cycle start pulse, honoured only in IDLE
//   abort         synchronous return to IDLE, flushes FIFO, clears junction_cnt
//   sensor[2:0]   raw IR line sensor {left, mid, right}, synchronised internally
//   cmd_wr_*      route command write port (00 straight, 01 left, 10 right, 11 back)
//   mode          registered motor mode code (state value)
//   last_mode     mode value held before the most recent mode change
//   junction_cnt  junctions entered, saturating at 255
//   busy/done/error  status decodes of the registered state
module nav_sequencer #(
    parameter int DEPTH     = 16,
    parameter int START_DLY = 100000000,
    parameter int CROSS_CYC = 20000000,
    parameter int TURN_MIN  = 30000000,
    parameter int TURN_MAX  = 200000000,
    parameter int LOST_MAX  = 50000000,
    parameter int CW        = 28
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] sensor,
    input  logic       cmd_wr_valid,
    input  logic [1:0] cmd_wr_data,
    output logic       cmd_wr_ready,
    output logic [4:0] mode,
    output logic [4:0] last_mode,
    output logic [7:0] junction_cnt,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    // Timer holds cycles already spent in the current state minus one, so the
    // "last cycle" thresholds below are the configured counts minus one.
    localparam logic [CW-1:0] START_LAST = CW'(START_DLY - 1);
    localparam logic [CW-1:0] CROSS_LAST = CW'(CROSS_CYC - 1);
    localparam logic [CW-1:0] TURN_LO    = CW'(TURN_MIN);
    localparam logic [CW-1:0] TURN_LAST  = CW'(TURN_MAX - 1);
    localparam logic [CW-1:0] LOST_LAST  = CW'(LOST_MAX - 1);

    typedef enum logic [4:0] {
        ST_IDLE         = 5'd0,
        ST_START        = 5'd1,
        ST_COUNT        = 5'd2,
        ST_STRAIGHT     = 5'd3,
        ST_CHOOSE       = 5'd4,
        ST_LEFT         = 5'd5,
        ST_RIGHT        = 5'd6,
        ST_BACK         = 5'd7,
        ST_LITTLE_LEFT  = 5'd8,
        ST_LITTLE_RIGHT = 5'd9,
        ST_STOP         = 5'd30,
        ST_ERROR        = 5'd31
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [2:0]    sensor_meta;
    logic [2:0]    s;
    logic [CW-1:0] timer;
    logic [CW-1:0] lost_cnt;

    logic [1:0]    fifo_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   fifo_cnt;
    logic [1:0]    cmd_lat;
    logic          cmd_present;

    logic          tracking;
    logic          line_lost;
    logic          fifo_empty;
    logic          fifo_full;
    logic          wr_en;
    logic          choose_entry;
    logic          pop;

`ifdef NAV_LOST_RECOVER_EN
    logic          recovering;
`endif

    assign mode         = state;
    assign tracking     = (state == ST_STRAIGHT) || (state == ST_LITTLE_LEFT) ||
                          (state == ST_LITTLE_RIGHT);
    assign line_lost    = (s == 3'b000) && (lost_cnt >= LOST_LAST);
    assign fifo_empty   = (fifo_cnt == '0);
    assign fifo_full    = (fifo_cnt == (AW+1)'(DEPTH));
    assign cmd_wr_ready = !fifo_full && !abort;
    assign wr_en        = cmd_wr_valid && cmd_wr_ready;
    // A command is consumed on the edge that enters CHOOSE, never later.
    assign choose_entry = (state_nx == ST_CHOOSE) && (state != ST_CHOOSE);
    assign pop          = choose_entry && !fifo_empty;

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state_nx = ST_START;
                ST_START: state_nx = ST_COUNT;
                ST_COUNT: if (timer >= START_LAST) state_nx = ST_STRAIGHT;
                ST_STRAIGHT, ST_LITTLE_LEFT, ST_LITTLE_RIGHT: begin
                    case (s)
                        3'b111:         state_nx = ST_CHOOSE;
                        3'b110, 3'b100: state_nx = ST_LITTLE_LEFT;
                        3'b011, 3'b001: state_nx = ST_LITTLE_RIGHT;
                        3'b010:         state_nx = ST_STRAIGHT;
                        3'b000: begin
                            if (line_lost) begin
`ifdef NAV_LOST_RECOVER_EN
                                if (recovering)
                                    state_nx = ST_ERROR;
                                else if (last_mode == ST_LITTLE_LEFT || last_mode == ST_LEFT)
                                    state_nx = ST_LITTLE_LEFT;
                                else
                                    state_nx = ST_LITTLE_RIGHT;
`else
                                state_nx = ST_ERROR;
`endif
                            end
                        end
                        default:        state_nx = state;  // 101: ambiguous, keep course
                    endcase
                end
                ST_CHOOSE: begin
                    if (!cmd_present) begin
                        state_nx = ST_STOP;
                    end else if (timer >= CROSS_LAST) begin
                        case (cmd_lat)
                            2'b00:   state_nx = ST_STRAIGHT;
                            2'b01:   state_nx = ST_LEFT;
                            2'b10:   state_nx = ST_RIGHT;
                            default: state_nx = ST_BACK;
                        endcase
                    end
                end
                ST_LEFT, ST_RIGHT, ST_BACK: begin
                    if (timer >= TURN_LO && s == 3'b010)
                        state_nx = ST_STRAIGHT;
                    else if (timer >= TURN_LAST)
                        state_nx = ST_ERROR;
                end
                default: state_nx = state;  // STOP, ERROR hold until abort
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            fifo_mem[wr_ptr] <= cmd_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sensor_meta  <= 3'b000;
            s            <= 3'b000;
            state        <= ST_IDLE;
            last_mode    <= 5'd0;
            timer        <= '0;
            lost_cnt     <= '0;
            junction_cnt <= 8'd0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fifo_cnt     <= '0;
            cmd_lat      <= 2'b00;
            cmd_present  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
`ifdef NAV_LOST_RECOVER_EN
            recovering   <= 1'b0;
`endif
        end else begin
            sensor_meta <= sensor;
            s           <= sensor_meta;

            state <= state_nx;
            busy  <= !((state_nx == ST_IDLE) || (state_nx == ST_STOP) || (state_nx == ST_ERROR));
            done  <= (state_nx == ST_STOP);
            error <= (state_nx == ST_ERROR);

            if (state_nx != state) begin
                timer     <= '0;
                last_mode <= state;
            end else if (timer != {CW{1'b1}}) begin
                timer <= timer + CW'(1);
            end

            // Run length of s == 000 while tracking; restarts on any line
            // sighting and after each lost-line decision.
            if (abort || !tracking || s != 3'b000 || line_lost)
                lost_cnt <= '0;
            else
                lost_cnt <= lost_cnt + CW'(1);

`ifdef NAV_LOST_RECOVER_EN
            if (abort || !tracking || s != 3'b000)
                recovering <= 1'b0;
            else if (line_lost)
                recovering <= 1'b1;
`endif

            if (abort) begin
                junction_cnt <= 8'd0;
                rd_ptr       <= '0;
                wr_ptr       <= '0;
                fifo_cnt     <= '0;
                cmd_present  <= 1'b0;
            end else begin
                if (choose_entry) begin
                    if (junction_cnt != 8'd255)
                        junction_cnt <= junction_cnt + 8'd1;
                    cmd_present <= !fifo_empty;
                end
                if (pop) begin
                    cmd_lat <= fifo_mem[rd_ptr];
                    rd_ptr  <= rd_ptr + AW'(1);
                end
                if (wr_en)
                    wr_ptr <= wr_ptr + AW'(1);
                case ({wr_en, pop})
                    2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                    2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                    default: fifo_cnt <= fifo_cnt;
                endcase
            end
        end
    end
endmodule
